// File: rtl/sumador_ctrl.sv
// sumador_ctrl: sequencer for a multi-cycle IEEE-754 single-precision adder.
//
// Accepts an operand pair on start&&ready, then walks the external adder
// datapath through four stages (compare, align/shift, add, normalize), each
// held for STAGE_CYCLES clock cycles, captures the normalized sum and pulses
// done for one cycle.
//
// Parameters
//   STAGE_CYCLES  cycles each stage enable stays high (legal 1..15)
//
// Ports
//   clk     in   1   single clock, rising edge
//   rst     in   1   synchronous active-high reset
//   start   in   1   request a new addition (taken only when ready)
//   A_in    in   32  operand A
//   B_in    in   32  operand B
//   ready   out  1   high only while idle
//   busy    out  1   high whenever not idle
//   opA     out  32  latched operand A to the datapath
//   opB     out  32  latched operand B to the datapath
//   en      out  4   stage enables: [3] compare, [2] align, [1] add, [0] normalize
//   num     in   32  normalized sum from the datapath
//   result  out  32  captured sum, held until the next completion
//   done    out  1   one-cycle pulse when result updates
//
// Build option
//   SUMADOR_CTRL_ZERO_BYPASS_EN  when defined, an operand whose magnitude
//   bits are all zero makes the other operand the result directly, skipping
//   the datapath stages (done one cycle after acceptance).

module sumador_ctrl #(
  parameter int STAGE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic        ready,
  output logic        busy,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [3:0]  en,
  input  logic [31:0] num,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    COMP,
    SHIFT,
    ADD,
    NORM,
    DONE
  } state_t;

  localparam logic [3:0] LASTCNT = 4'(STAGE_CYCLES - 1);

  state_t     state;
  state_t     nextstate;
  logic [3:0] cnt;
  logic       stagedone;
  logic       accept;
  logic       instage;

`ifdef SUMADOR_CTRL_ZERO_BYPASS_EN
  // Sign bit is ignored so that -0.0 also counts as zero.
  logic azero;
  logic bzero;
  assign azero = (A_in[30:0] == 31'd0);
  assign bzero = (B_in[30:0] == 31'd0);
`endif

  assign stagedone = (cnt == LASTCNT);
  assign accept    = start && (state == IDLE);
  assign instage   = (state == COMP) || (state == SHIFT) ||
                     (state == ADD)  || (state == NORM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextstate;
    end
  end

  always_comb begin
    nextstate = state;
    en        = 4'b0000;
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
`ifdef SUMADOR_CTRL_ZERO_BYPASS_EN
          nextstate = (azero || bzero) ? DONE : COMP;
`else
          nextstate = COMP;
`endif
        end
      end
      COMP: begin
        en = 4'b1000;
        if (stagedone) nextstate = SHIFT;
      end
      SHIFT: begin
        en = 4'b0100;
        if (stagedone) nextstate = ADD;
      end
      ADD: begin
        en = 4'b0010;
        if (stagedone) nextstate = NORM;
      end
      NORM: begin
        en = 4'b0001;
        if (stagedone) nextstate = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextstate = IDLE;
      end
      default: begin
        nextstate = IDLE;
      end
    endcase
  end

  // Operand/result registers and the per-stage cycle counter. The counter
  // is held at zero outside the stages, so every stage entry starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      opA    <= 32'd0;
      opB    <= 32'd0;
      result <= 32'd0;
    end else begin
      if (accept) begin
        opA <= A_in;
        opB <= B_in;
`ifdef SUMADOR_CTRL_ZERO_BYPASS_EN
        if (azero) begin
          result <= B_in;
        end else if (bzero) begin
          result <= A_in;
        end
`endif
      end

      if (instage && !stagedone) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end

      if ((state == NORM) && stagedone) begin
        result <= num;
      end
    end
  end

endmodule

// File: tb/tb_sumador_ctrl.sv
// tb_sumador_ctrl: self-checking bench for sumador_ctrl.
//
// Two instances share all inputs: index 0 uses STAGE_CYCLES=1, index 1 uses
// STAGE_CYCLES=3. A behavioural model tracks, per instance, how many cycles
// have elapsed since an operation was accepted and derives every output from
// that; a compare process checks both instances each cycle. Directed
// sequences add literal expectations for en sequences, done timing and
// result values.

module tb_sumador_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] num;

  logic        ready  [2];
  logic        busy   [2];
  logic        done   [2];
  logic [31:0] opA    [2];
  logic [31:0] opB    [2];
  logic [31:0] result [2];
  logic [3:0]  en     [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tAcc = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : inst
    sumador_ctrl #(.STAGE_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A_in  (A_in),
      .B_in  (B_in),
      .ready (ready[g]),
      .busy  (busy[g]),
      .opA   (opA[g]),
      .opB   (opB[g]),
      .en    (en[g]),
      .num   (num),
      .result(result[g]),
      .done  (done[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] n);
    start = s;
    A_in  = a;
    B_in  = b;
    num   = n;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: phase 0 = idle, 1..4*sc = stage cycles,
  // 4*sc+1 = completion cycle.
  int          sc [2] = '{1, 3};
  int          phase [2];
  logic [31:0] mOpA [2];
  logic [31:0] mOpB [2];
  logic [31:0] mRes [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i] = 0;
        mOpA[i]  = 32'd0;
        mOpB[i]  = 32'd0;
        mRes[i]  = 32'd0;
      end else if (phase[i] == 0) begin
        if (start) begin
          mOpA[i]  = A_in;
          mOpB[i]  = B_in;
          phase[i] = 1;
`ifdef SUMADOR_CTRL_ZERO_BYPASS_EN
          if (A_in[30:0] == 31'd0) begin
            mRes[i]  = B_in;
            phase[i] = 4 * sc[i] + 1;
          end else if (B_in[30:0] == 31'd0) begin
            mRes[i]  = A_in;
            phase[i] = 4 * sc[i] + 1;
          end
`endif
        end
      end else if (phase[i] == 4 * sc[i] + 1) begin
        phase[i] = 0;
      end else begin
        if (phase[i] == 4 * sc[i]) mRes[i] = num;
        phase[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] expEn;
        int p;
        p = phase[i];
        expEn = 4'b0000;
        if (p >= 1 && p <= 4 * sc[i]) expEn = 4'b1000 >> ((p - 1) / sc[i]);
        checkOutput($sformatf("model ready[%0d]", i), 32'(ready[i]), 32'(p == 0));
        checkOutput($sformatf("model busy[%0d]", i), 32'(busy[i]), 32'(p != 0));
        checkOutput($sformatf("model done[%0d]", i), 32'(done[i]), 32'(p == 4 * sc[i] + 1));
        checkOutput($sformatf("model en[%0d]", i), 32'(en[i]), 32'(expEn));
        checkOutput($sformatf("model opA[%0d]", i), opA[i], mOpA[i]);
        checkOutput($sformatf("model opB[%0d]", i), opB[i], mOpB[i]);
        checkOutput($sformatf("model result[%0d]", i), result[i], mRes[i]);
      end
    end
  end

  // Done-pulse log in spec cycle numbering (cycle after edge n is n+1).
  int doneLog0[$];
  int doneCnt1 = 0;

  always @(negedge clk) begin
    if (checkEn) begin
      if (done[0] === 1'b1) doneLog0.push_back(cyc + 1);
      if (done[1] === 1'b1) doneCnt1++;
    end
  end

  logic [3:0] en0Tab [14] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] en1Tab [14] = '{4'h8, 4'h8, 4'h8, 4'h4, 4'h4, 4'h4, 4'h2,
                              4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};

  initial begin
    logic [3:0] enSeen;
    int expDoneAt;
    logic [31:0] expRes;

    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    waitCycles(1);
    rst = 1'b0;

    checkOutput("reset ready", 32'(ready[0]), 32'd1);
    checkOutput("reset busy", 32'(busy[0]), 32'd0);
    checkOutput("reset en", 32'(en[0]), 32'd0);
    checkOutput("reset result", result[0], 32'd0);
    checkOutput("reset opA", opA[1], 32'd0);

    // 1.0 + 2.0 on both instances, A_in disturbed while busy
    $display("[TB] basic addition, STAGE_CYCLES 1 and 3");
    applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    tAcc = cyc + 1;
    waitCycles(1);
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      checkOutput($sformatf("en0 t+%0d", k), 32'(en[0]), 32'(en0Tab[k-1]));
      checkOutput($sformatf("en1 t+%0d", k), 32'(en[1]), 32'(en1Tab[k-1]));
      checkOutput($sformatf("done0 t+%0d", k), 32'(done[0]), 32'(k == 5));
      checkOutput($sformatf("done1 t+%0d", k), 32'(done[1]), 32'(k == 13));
      if (k <= 5) checkOutput($sformatf("opA0 hold t+%0d", k), opA[0], 32'h3F80_0000);
      if (k <= 13) checkOutput($sformatf("opA1 hold t+%0d", k), opA[1], 32'h3F80_0000);
      if (k == 2) A_in = 32'h4120_0000;
      waitCycles(1);
    end
    checkOutput("result0 1+2", result[0], 32'h4040_0000);
    checkOutput("result1 1+2", result[1], 32'h4040_0000);
    A_in = 32'h3F80_0000;

    // Reset while instance 0 is aligning
    $display("[TB] reset during SHIFT");
    applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    waitCycles(1);
    start = 1'b0;
    waitCycles(1);
    checkOutput("en0 in SHIFT", 32'(en[0]), 32'h4);
    doneLog0.delete();
    doneCnt1 = 0;
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rst en0", 32'(en[0]), 32'd0);
    checkOutput("rst result0", result[0], 32'd0);
    checkOutput("rst ready0", 32'(ready[0]), 32'd1);
    checkOutput("rst busy0", 32'(busy[0]), 32'd0);
    checkOutput("rst result1", result[1], 32'd0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(16);
    checkOutput("rst no done0", 32'(doneLog0.size()), 32'd0);
    checkOutput("rst no done1", 32'(doneCnt1), 32'd0);

    // start held for 20 cycles
    $display("[TB] start held high");
    doneLog0.delete();
    applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    tAcc = cyc + 1;
    waitCycles(20);
    start = 1'b0;
    waitCycles(30);
    checkOutput("held done count", 32'(doneLog0.size()), 32'd4);
    if (doneLog0.size() >= 3) begin
      checkOutput("held done 1", 32'(doneLog0[0] - tAcc), 32'd5);
      checkOutput("held done 2", 32'(doneLog0[1] - tAcc), 32'd11);
      checkOutput("held done 3", 32'(doneLog0[2] - tAcc), 32'd17);
    end else begin
      checkOutput("held done log length", 32'(doneLog0.size()), 32'd3);
    end

    // -0.0 + 5.0
    $display("[TB] zero operand");
`ifdef SUMADOR_CTRL_ZERO_BYPASS_EN
    expDoneAt = 1;
    expRes    = 32'h40A0_0000;
`else
    expDoneAt = 5;
    expRes    = 32'h1234_5678;
`endif
    doneLog0.delete();
    enSeen = 4'b0000;
    applyStimulus(1'b1, 32'h8000_0000, 32'h40A0_0000, 32'h1234_5678);
    tAcc = cyc + 1;
    waitCycles(1);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      enSeen = enSeen | en[0];
      waitCycles(1);
    end
    if (doneLog0.size() >= 1) begin
      checkOutput("zero done time", 32'(doneLog0[0] - tAcc), 32'(expDoneAt));
    end else begin
      checkOutput("zero done seen", 32'd0, 32'd1);
    end
    checkOutput("zero result", result[0], expRes);
`ifdef SUMADOR_CTRL_ZERO_BYPASS_EN
    checkOutput("zero en seen", 32'(enSeen), 32'h0);
`else
    checkOutput("zero en seen", 32'(enSeen), 32'hF);
`endif

    waitCycles(20);
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
